// File: rtl/accel_spi_reader.sv
// ADXL345 single-axis reader: configures the sensor over SPI mode 3, then samples one axis and scales it to signed 8 bits.
// Latency: G_DATA/G_VALID update on the CLK edge where SPI_CS_N rises, CLK_DIV cycles after the last SCLK rising edge.
// Backpressure: none; a sample tick that arrives while a read is in flight (or during the CS-high gap) is dropped.
//
// Ports:
//   CLK, RST_N          - system clock, asynchronous active-low reset
//   SPI_CS_N, SPI_SCLK  - chip select and SPI clock (mode 3, SCLK idles high)
//   SPI_SDO, SPI_SDI    - serial data to / from the sensor, MSB first
//   G_DATA, G_VALID     - saturated signed axis value and its one-cycle update strobe
//   READY               - high once both configuration writes have completed
//
// Optional feature macro: ACCEL_AVG_EN -- when defined, G_DATA is the scaled sum of every
// 4 consecutive reads and G_VALID pulses once per group of four.

module accel_spi_reader #(
    parameter int unsigned CLK_DIV     = 25,
    parameter int unsigned STARTUP_CYC = 100000,
    parameter int unsigned SAMPLE_DIV  = 500000,
    parameter logic [5:0]  AXIS_ADDR   = 6'h32
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic       SPI_CS_N,
    output logic       SPI_SCLK,
    output logic       SPI_SDO,
    input  logic       SPI_SDI,
    output logic [7:0] G_DATA,
    output logic       G_VALID,
    output logic       READY
);

    localparam int HPW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GPW = $clog2(2 * CLK_DIV + 1);
    localparam int SCW = $clog2(STARTUP_CYC + 1);
    localparam int SPW = $clog2(SAMPLE_DIV + 1);

    localparam logic [HPW-1:0] HP_LAST    = HPW'(CLK_DIV - 1);
    localparam logic [GPW-1:0] GAP_LOAD   = GPW'(2 * CLK_DIV);
    localparam logic [SCW-1:0] START_LAST = SCW'(STARTUP_CYC - 1);
    localparam logic [SPW-1:0] SAMP_LAST  = SPW'(SAMPLE_DIV - 1);

    // Half-period boundary at which CS is released: 2*bits edges, then one more half-period.
    localparam logic [5:0] HP_END_16 = 6'd33;
    localparam logic [5:0] HP_END_24 = 6'd49;

    localparam logic [2:0] S_WAIT_START = 3'd0;
    localparam logic [2:0] S_WR_FMT     = 3'd1;
    localparam logic [2:0] S_WR_PWR     = 3'd2;
    localparam logic [2:0] S_IDLE       = 3'd3;
    localparam logic [2:0] S_READ       = 3'd4;
    localparam logic [2:0] S_UPDATE     = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [SCW-1:0] start_cnt_q;
    logic [SPW-1:0] samp_cnt_q;
    logic [GPW-1:0] gap_q;

    logic           busy_q;
    logic [HPW-1:0] hp_cnt_q;
    logic [5:0]     hp_idx_q;
    logic [5:0]     hp_end_at_q;
    logic [23:0]    tx_q;
    logic [15:0]    rx_q;
    logic           cs_n_q, sclk_q, sdo_q;

    logic           ready_q, g_valid_q;
    logic [7:0]     g_data_q;

    logic           hp_end, xfer_done, tick, gap_zero;
    logic [5:0]     hp_num;
    logic           go;
    logic [23:0]    go_tx;
    logic [5:0]     go_end;

    logic [15:0]        raw;
    logic signed [17:0] raw_ext;

    function automatic logic [7:0] sat8(input logic signed [17:0] v);
        if (v > 18'sd127) begin
            return 8'h7F;
        end else if (v < -18'sd128) begin
            return 8'h80;
        end
        return v[7:0];
    endfunction

    assign hp_end    = busy_q && (hp_cnt_q == HP_LAST);
    assign hp_num    = hp_idx_q + 6'd1;
    assign xfer_done = hp_end && (hp_num == hp_end_at_q);
    assign tick      = ready_q && (samp_cnt_q == SAMP_LAST);
    assign gap_zero  = (gap_q == '0);

    // rx_q holds MISO bits 8..23 in arrival order: low byte first, then high byte.
    assign raw     = {rx_q[7:0], rx_q[15:8]};
    assign raw_ext = {{2{raw[15]}}, raw};

    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        go_tx   = 24'h000000;
        go_end  = HP_END_16;
        case (state_q)
            S_WAIT_START: begin
                if (start_cnt_q == START_LAST) state_d = S_WR_FMT;
            end
            S_WR_FMT: begin
                go_tx = {8'h31, 8'h00, 8'h00};
                go    = !busy_q && gap_zero;
                if (xfer_done) state_d = S_WR_PWR;
            end
            S_WR_PWR: begin
                go_tx = {8'h2D, 8'h08, 8'h00};
                go    = !busy_q && gap_zero;
                if (xfer_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                go_tx  = {1'b1, 1'b1, AXIS_ADDR, 16'h0000};
                go_end = HP_END_24;
                // A tick landing in the CS-high gap is dropped like any other busy-time tick.
                go     = tick && !busy_q && gap_zero;
                if (go) state_d = S_READ;
            end
            S_READ: begin
                if (xfer_done) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_WAIT_START;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_WAIT_START;
            start_cnt_q <= '0;
            samp_cnt_q  <= '0;
            gap_q       <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT_START) start_cnt_q <= start_cnt_q + 1'b1;

            // Free-running sample timer, phase-locked to the rise of READY.
            if (!ready_q || samp_cnt_q == SAMP_LAST) samp_cnt_q <= '0;
            else                                     samp_cnt_q <= samp_cnt_q + 1'b1;

            if (xfer_done)      gap_q <= GAP_LOAD;
            else if (!gap_zero) gap_q <= gap_q - 1'b1;

            if (xfer_done && state_q == S_WR_PWR) ready_q <= 1'b1;
        end
    end

    // SPI shifter. Odd half-period boundaries are SCLK falls, even ones are rises.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q      <= 1'b0;
            hp_cnt_q    <= '0;
            hp_idx_q    <= '0;
            hp_end_at_q <= HP_END_16;
            tx_q        <= '0;
            rx_q        <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            sdo_q       <= 1'b0;
        end else if (go) begin
            busy_q      <= 1'b1;
            cs_n_q      <= 1'b0;
            sdo_q       <= go_tx[23];
            tx_q        <= {go_tx[22:0], 1'b0};
            hp_cnt_q    <= '0;
            hp_idx_q    <= '0;
            hp_end_at_q <= go_end;
        end else if (busy_q) begin
            if (hp_end) begin
                hp_cnt_q <= '0;
                hp_idx_q <= hp_num;
                if (xfer_done) begin
                    busy_q <= 1'b0;
                    cs_n_q <= 1'b1;
                    sdo_q  <= 1'b0;
                end else if (hp_num[0]) begin
                    sclk_q <= 1'b0;
                    // Bit 0 is already on the line before the first fall.
                    if (hp_num != 6'd1) begin
                        sdo_q <= tx_q[23];
                        tx_q  <= {tx_q[22:0], 1'b0};
                    end
                end else begin
                    sclk_q <= 1'b1;
                    rx_q   <= {rx_q[14:0], SPI_SDI};
                end
            end else begin
                hp_cnt_q <= hp_cnt_q + 1'b1;
            end
        end
    end

`ifdef ACCEL_AVG_EN
    logic signed [17:0] acc_q;
    logic [1:0]         rd_cnt_q;
    logic signed [17:0] sum;

    assign sum = acc_q + raw_ext;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q     <= '0;
            rd_cnt_q  <= '0;
            g_data_q  <= 8'h00;
            g_valid_q <= 1'b0;
        end else begin
            g_valid_q <= 1'b0;
            if (xfer_done && state_q == S_READ) begin
                if (rd_cnt_q == 2'd3) begin
                    g_data_q  <= sat8(sum >>> 4);
                    g_valid_q <= 1'b1;
                    acc_q     <= '0;
                    rd_cnt_q  <= '0;
                end else begin
                    acc_q    <= sum;
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            g_data_q  <= 8'h00;
            g_valid_q <= 1'b0;
        end else begin
            g_valid_q <= 1'b0;
            if (xfer_done && state_q == S_READ) begin
                g_data_q  <= sat8(raw_ext >>> 2);
                g_valid_q <= 1'b1;
            end
        end
    end
`endif

    assign SPI_CS_N = cs_n_q;
    assign SPI_SCLK = sclk_q;
    assign SPI_SDO  = sdo_q;
    assign G_DATA   = g_data_q;
    assign G_VALID  = g_valid_q;
    assign READY    = ready_q;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: an ADXL345 mode-3 slave model feeds raw readings, a scoreboard
// queue holds the expected G_DATA values, and a monitor pops them on each G_VALID.
// A second instance with a short sample period checks tick dropping and frame separation.
`timescale 1ns/1ps
module tb_accel_spi_reader;

    localparam int CLK_DIV      = 2;
    localparam int STARTUP_CYC  = 10;
    localparam int SAMPLE_DIV   = 200;
    localparam int SAMPLE_DIV_B = 40;

`ifdef ACCEL_AVG_EN
    localparam int TGT1 = 2;
    localparam int TGT2 = 1;
`else
    localparam int TGT1 = 6;
    localparam int TGT2 = 3;
`endif

    logic       clk, rst_n;
    logic       spi_cs_n, spi_sclk, spi_sdo, spi_sdi;
    logic [7:0] g_data;
    logic       g_valid, ready;
    logic       b_cs_n, b_sclk, b_sdo, b_sdi;
    logic [7:0] b_g_data;
    logic       b_g_valid, b_ready;

    accel_spi_reader #(
        .CLK_DIV(CLK_DIV), .STARTUP_CYC(STARTUP_CYC), .SAMPLE_DIV(SAMPLE_DIV), .AXIS_ADDR(6'h32)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .SPI_CS_N(spi_cs_n), .SPI_SCLK(spi_sclk), .SPI_SDO(spi_sdo),
        .SPI_SDI(spi_sdi), .G_DATA(g_data), .G_VALID(g_valid), .READY(ready)
    );

    accel_spi_reader #(
        .CLK_DIV(CLK_DIV), .STARTUP_CYC(STARTUP_CYC), .SAMPLE_DIV(SAMPLE_DIV_B), .AXIS_ADDR(6'h32)
    ) dut_b (
        .CLK(clk), .RST_N(rst_n), .SPI_CS_N(b_cs_n), .SPI_SCLK(b_sclk), .SPI_SDO(b_sdo),
        .SPI_SDI(b_sdi), .G_DATA(b_g_data), .G_VALID(b_g_valid), .READY(b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_upd = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] dir_q[$];

    logic        a_prev_cs, a_prev_sclk, a_prev_rdy, m_prev_valid, b_prev_cs;
    int          in_frame, frame_idx, rises, falls;
    logic [23:0] mosi, miso_word;
    logic [15:0] raw;
    int          rv, fall_cyc, last_rise_cyc, rise_cyc, have_rise, ready_cyc, last_read_fall;
    int          avg_sum, avg_n;
    int          b_frame_idx, b_have_rise, b_rise_cyc, b_last_read_fall, n40;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Spec-level scaling: arithmetic shift then clamp to the signed 8-bit range.
    function automatic logic [7:0] clamp8(input int v);
        if (v > 127)  return 8'h7F;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0; frame_idx = 0; rises = 0; falls = 0; have_rise = 0;
            last_read_fall = -1; avg_sum = 0; avg_n = 0; spi_sdi = 1'b0;
            b_frame_idx = 0; b_have_rise = 0; b_last_read_fall = -1;
        end else begin
            if (!a_prev_rdy && ready) ready_cyc = cyc;

            // ---- slave model, main instance ----
            if (a_prev_cs && !spi_cs_n) begin
                if (have_rise != 0) check("cs_high_gap", 32'(cyc - rise_cyc >= 2 * CLK_DIV), 1);
                in_frame = 1; rises = 0; falls = 0; mosi = '0; miso_word = '0; fall_cyc = cyc;
                if (frame_idx >= 2) begin
                    if (last_read_fall < 0) check("first_read_delay", cyc - ready_cyc, SAMPLE_DIV);
                    else                    check("read_spacing", cyc - last_read_fall, SAMPLE_DIV);
                    last_read_fall = cyc;
                    if (dir_q.size() > 0) raw = dir_q.pop_front();
                    else                  raw = 16'($urandom);
                    miso_word = {8'h00, raw[7:0], raw[15:8]};
                    rv = int'($signed(raw));
`ifdef ACCEL_AVG_EN
                    avg_sum += rv;
                    avg_n++;
                    if (avg_n == 4) begin
                        exp_q.push_back(clamp8(avg_sum >>> 4));
                        avg_sum = 0;
                        avg_n = 0;
                    end
`else
                    exp_q.push_back(clamp8(rv >>> 2));
`endif
                end
            end
            if (in_frame != 0 && a_prev_sclk && !spi_sclk) begin
                if (falls == 0) check("cs_to_first_fall", cyc - fall_cyc, CLK_DIV);
                if (falls < 24) spi_sdi = miso_word[23 - falls];
                falls++;
            end
            if (in_frame != 0 && !a_prev_sclk && spi_sclk) begin
                mosi = {mosi[22:0], spi_sdo};
                rises++;
                last_rise_cyc = cyc;
            end
            if (in_frame != 0 && !a_prev_cs && spi_cs_n) begin
                in_frame = 0; have_rise = 1; rise_cyc = cyc;
                check("last_rise_to_cs", cyc - last_rise_cyc, CLK_DIV);
                if (frame_idx == 0) begin
                    check("fmt_bits", rises, 16);
                    check("fmt_mosi", mosi[15:0], 16'h3100);
                    check("ready_after_fmt", ready, 0);
                end else if (frame_idx == 1) begin
                    check("pwr_bits", rises, 16);
                    check("pwr_mosi", mosi[15:0], 16'h2D08);
                    check("ready_after_pwr", ready, 1);
                end else begin
                    check("read_bits", rises, 24);
                    check("read_cmd", mosi[23:16], 8'hF2);
                    check("read_mosi_tail", mosi[15:0], 16'h0000);
                end
                frame_idx++;
            end

            // ---- output monitor / scoreboard ----
            if (g_valid) begin
                check("g_valid_single", m_prev_valid, 0);
                check("valid_at_cs_rise", {a_prev_cs, spi_cs_n}, 2'b01);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_update: got G_DATA=0x%0h, want no update", g_data);
                end else begin
                    check("g_data", g_data, exp_q.pop_front());
                    n_upd++;
                end
            end

            // ---- short-period instance: dropped ticks, no overlap ----
            if (b_prev_cs && !b_cs_n) begin
                if (b_have_rise != 0) check("b_cs_high_gap", 32'(cyc - b_rise_cyc >= 2 * CLK_DIV), 1);
                if (b_frame_idx >= 2) begin
                    if (b_last_read_fall >= 0) begin
                        check("b_spacing_mult", (cyc - b_last_read_fall) % SAMPLE_DIV_B, 0);
                        check("b_tick_dropped", 32'(cyc - b_last_read_fall > SAMPLE_DIV_B), 1);
                        n40++;
                    end
                    b_last_read_fall = cyc;
                end
            end
            if (!b_prev_cs && b_cs_n) begin
                b_have_rise = 1;
                b_rise_cyc = cyc;
                b_frame_idx++;
            end
        end
        a_prev_cs    = spi_cs_n;
        a_prev_sclk  = spi_sclk;
        a_prev_rdy   = ready;
        m_prev_valid = g_valid;
        b_prev_cs    = b_cs_n;
    end

    task automatic wait_updates(input int target, input string name);
        for (int i = 0; i < 20000 && n_upd < target; i++) @(posedge clk);
        check(name, 32'(n_upd >= target), 1);
    endtask

    initial begin
        rst_n = 1'b0; spi_sdi = 1'b0; b_sdi = 1'b0; n40 = 0;
        a_prev_cs = 1'b1; a_prev_sclk = 1'b1; a_prev_rdy = 1'b0; m_prev_valid = 1'b0; b_prev_cs = 1'b1;
        ready_cyc = 0; fall_cyc = 0; rise_cyc = 0; last_rise_cyc = 0; b_rise_cyc = 0;
`ifdef ACCEL_AVG_EN
        dir_q = '{16'd256, 16'd256, 16'd256, 16'd0};
`else
        dir_q = '{16'h0100, 16'hFF00, 16'h7FFF, 16'h8000};
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sclk", spi_sclk, 1);
        check("rst_sdo", spi_sdo, 0);
        check("rst_g_data", g_data, 8'h00);
        check("rst_g_valid", g_valid, 0);
        check("rst_ready", ready, 0);
        #1 rst_n = 1'b1;

        wait_updates(TGT1, "timeout_first_updates");

        // Abort a read while bit 12 is on the wire.
        for (int i = 0; i < 5000 && !(in_frame != 0 && frame_idx >= 2 && rises == 12); i++) @(posedge clk);
        check("mid_read_found", rises, 12);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_cs_n", spi_cs_n, 1);
        check("abort_sclk", spi_sclk, 1);
        check("abort_sdo", spi_sdo, 0);
        check("abort_g_data", g_data, 8'h00);
        check("abort_g_valid", g_valid, 0);
        check("abort_ready", ready, 0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;

        wait_updates(n_upd + TGT2, "timeout_after_reset");
        check("b_reads_seen", 32'(n40 >= 2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
